escritura_memoria_to_registro: RTL and testbench
================================================

Name: escritura_memoria_to_registro

Overview:
- Write-side bus front end for the neural network core; the companion to the readback path that exposes the ready flag (0x000), result (0x001) and error flag (0x004).
- The processor writes input samples and commands over the 9-bit address bus.
- The block buffers Depth signed samples, then streams them to the core under a valid/ready handshake.
- It waits for the core's done indication and provides sticky overrun and error-clear control.

Parameters:
- Width, 24, bit width of signed data samples, matching the readback path.
- Depth, 4, number of input samples per inference (buffer depth, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Write  input  1  bus write strobe, one access per cycle.
- Address  input  9  bus write address.
- InDato  input  Width  signed bus write data.
- CoreReady  input  1  core accepts the current sample.
- CoreDone  input  1  core finished inference (same signal as the readback ListoIn).
- OutDato  output  Width  signed sample presented to the core.
- OutValid  output  1  OutDato is valid.
- StartOut  output  1  one-cycle pulse marking the start of a sample stream.
- ClearError  output  1  one-cycle pulse clearing the core error flag.
- Overrun  output  1  sticky flag: a data write was dropped.
- Busy  output  1  high whenever the state is not IDLE.
- Count  output  $clog2(Depth+1)  number of buffered samples.

Behaviour:
- Reset (asynchronous, any time including mid-stream):
  - State goes to IDLE; buffer, pointers and Count go to 0.
  - OutDato=0, OutValid=0, StartOut=0, ClearError=0, Overrun=0, Busy=0.
- All outputs are registered. A write sampled at edge N takes effect in the cycle after edge N.
- Address map (writes only; any other address is ignored):
  - 0x002 (data):
    - In IDLE with Count<Depth: buf[Count]<=InDato, Count+1.
    - Otherwise (buffer full or not IDLE): data dropped, Overrun<=1.
  - 0x003 (start), InDato==1:
    - Accepted only in IDLE with Count==Depth.
    - Otherwise ignored with no side effects.
    - Any other InDato value is ignored.
  - 0x005 (error clear), InDato==1:
    - ClearError pulses high for exactly one cycle; Overrun<=0.
    - Valid in any state.
  - 0x006 (flush), InDato==1:
    - State goes to IDLE; Count, pointers, OutValid and StartOut go to 0.
    - Overrun is unchanged; buffer contents are don't-care.
- State machine (IDLE, STREAM, WAIT_DONE):
  - IDLE -> STREAM on an accepted start: StartOut=1 for one cycle, OutValid=1, OutDato=buf[0], rd_ptr=0.
  - STREAM:
    - OutDato=buf[rd_ptr] and OutValid=1 are held stable until CoreReady=1.
    - On a cycle with OutValid&&CoreReady, rd_ptr advances and the next sample appears the following cycle.
    - If rd_ptr==Depth-1 in that cycle, go to WAIT_DONE with OutValid=0 and OutDato=0.
    - CoreDone in STREAM is ignored.
  - WAIT_DONE:
    - On CoreDone=1, go to IDLE with Count=0 and pointers 0.
    - A new batch can then be written.
- Simultaneous events:
  - Flush has priority over CoreDone, start and data writes.
  - A data-drop event in the same cycle as an error-clear write leaves Overrun=1 (set wins).
  - ClearError still pulses in that case.
- Count saturates at Depth and never wraps. rd_ptr never exceeds Depth-1.
- No arithmetic is performed on samples: signed values pass through bit-exact.

Test Plan:
- Reset, write 0x002 with 10, -5, 7, 0x7FFFFF, then write 0x003=1 with CoreReady=1:
  - Count=4 before the start.
  - StartOut pulses once.
  - OutDato sequence is 10, -5, 7, 0x7FFFFF on consecutive cycles, then OutValid=0 and Busy=1.
  - CoreDone -> Busy=0, Count=0.
- Stream with CoreReady low for 3 cycles on the 2nd sample -> OutDato holds -5 with OutValid=1 for those 3 cycles; no sample is skipped or repeated.
- Fifth data write with Count=4 -> Count stays 4 and Overrun=1. A following 0x005=1 write -> ClearError pulses 1 cycle and Overrun=0.
- Start write with Count=2 -> no StartOut and state stays IDLE. A data write during STREAM -> Overrun=1 and the buffer is unchanged.
- Flush (0x006=1) mid-STREAM -> next cycle OutValid=0, Busy=0, Count=0. Assert reset mid-WAIT_DONE -> all outputs are immediately 0 without waiting for a clock edge.
- Write 0x000, 0x001, 0x004 and 0x003 with InDato=2 -> no state or output change.

Source files
------------

// File: rtl/escritura_memoria_to_registro.sv
// Write-side bus front end: buffers Depth signed samples from the processor bus
// and streams them to the neural network core under a valid/ready handshake.
module escritura_memoria_to_registro #(
  parameter int Width = 24,
  parameter int Depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Write,
  input  logic [8:0]                 Address,
  input  logic signed [Width-1:0]    InDato,
  input  logic                       CoreReady,
  input  logic                       CoreDone,
  output logic signed [Width-1:0]    OutDato,
  output logic                       OutValid,
  output logic                       StartOut,
  output logic                       ClearError,
  output logic                       Overrun,
  output logic                       Busy,
  output logic [$clog2(Depth+1)-1:0] Count
);

  localparam int CW = $clog2(Depth + 1);
  localparam int PW = $clog2(Depth);

  localparam logic [8:0] ADDR_DATA  = 9'h002;
  localparam logic [8:0] ADDR_START = 9'h003;
  localparam logic [8:0] ADDR_CLEAR = 9'h005;
  localparam logic [8:0] ADDR_FLUSH = 9'h006;

  localparam logic signed [Width-1:0] CMD_ONE = Width'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [Width-1:0] r_buf [Depth];
  logic [CW-1:0]           r_count;
  logic [PW-1:0]           r_rd_ptr;
  logic signed [Width-1:0] r_dato;
  logic                    r_valid;
  logic                    r_start;
  logic                    r_clear;
  logic                    r_overrun;
  logic                    r_busy;

  logic          w_wr_data;
  logic          w_wr_start;
  logic          w_wr_clear;
  logic          w_wr_flush;
  logic          w_full;
  logic          w_accept_data;
  logic [PW-1:0] w_wr_idx;

  // Command writes only act when the data word is exactly 1.
  assign w_wr_data     = Write && (Address == ADDR_DATA);
  assign w_wr_start    = Write && (Address == ADDR_START) && (InDato == CMD_ONE);
  assign w_wr_clear    = Write && (Address == ADDR_CLEAR) && (InDato == CMD_ONE);
  assign w_wr_flush    = Write && (Address == ADDR_FLUSH) && (InDato == CMD_ONE);
  assign w_full        = (r_count == CW'(Depth));
  assign w_accept_data = w_wr_data && (r_state == IDLE) && !w_full;
  assign w_wr_idx      = r_count[PW-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_dato    <= '0;
      r_valid   <= 1'b0;
      r_start   <= 1'b0;
      r_clear   <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
      // NOTE: the sample buffer is cleared too, so reset leaves no stale data
      // visible; a plain storage array would normally be left unreset.
      for (int i = 0; i < Depth; i++) r_buf[i] <= '0;
    end else begin
      r_clear <= w_wr_clear;

      // Clear first, then set, so a drop in the same cycle leaves Overrun high.
      if (w_wr_clear) r_overrun <= 1'b0;
      if (w_wr_data && !w_accept_data) r_overrun <= 1'b1;

      if (w_wr_flush) begin
        r_state  <= IDLE;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_dato   <= '0;
        r_valid  <= 1'b0;
        r_start  <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        r_start <= 1'b0;
        case (r_state)
          IDLE: begin
            if (w_accept_data) begin
              r_buf[w_wr_idx] <= InDato;
              r_count         <= r_count + CW'(1);
            end else if (w_wr_start && w_full) begin
              r_state  <= STREAM;
              r_start  <= 1'b1;
              r_valid  <= 1'b1;
              r_dato   <= r_buf[0];
              r_rd_ptr <= '0;
              r_busy   <= 1'b1;
            end
          end

          STREAM: begin
            if (r_valid && CoreReady) begin
              if (r_rd_ptr == PW'(Depth - 1)) begin
                r_state <= WAIT_DONE;
                r_valid <= 1'b0;
                r_dato  <= '0;
              end else begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_dato   <= r_buf[r_rd_ptr + PW'(1)];
              end
            end
          end

          WAIT_DONE: begin
            if (CoreDone) begin
              r_state  <= IDLE;
              r_count  <= '0;
              r_rd_ptr <= '0;
              r_busy   <= 1'b0;
            end
          end

          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign OutDato    = r_dato;
  assign OutValid   = r_valid;
  assign StartOut   = r_start;
  assign ClearError = r_clear;
  assign Overrun    = r_overrun;
  assign Busy       = r_busy;
  assign Count      = r_count;

endmodule

// File: tb/tb_escritura_memoria_to_registro.sv
// Directed bench for escritura_memoria_to_registro: a table of bus/handshake
// vectors with hand-computed outputs, plus reset-during-wait sequences.
module tb_escritura_memoria_to_registro;

  localparam int W = 24;
  localparam int D = 4;

  logic                clk;
  logic                reset;
  logic                Write;
  logic [8:0]          Address;
  logic signed [W-1:0] InDato;
  logic                CoreReady;
  logic                CoreDone;
  logic signed [W-1:0] OutDato;
  logic                OutValid;
  logic                StartOut;
  logic                ClearError;
  logic                Overrun;
  logic                Busy;
  logic [2:0]          Count;

  int tests_run = 0;
  int tests_failed = 0;

  escritura_memoria_to_registro #(.Width(W), .Depth(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .Write      (Write),
    .Address    (Address),
    .InDato     (InDato),
    .CoreReady  (CoreReady),
    .CoreDone   (CoreDone),
    .OutDato    (OutDato),
    .OutValid   (OutValid),
    .StartOut   (StartOut),
    .ClearError (ClearError),
    .Overrun    (Overrun),
    .Busy       (Busy),
    .Count      (Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                wr;
    logic [8:0]          addr;
    logic signed [W-1:0] data;
    logic                cr;
    logic                cd;
    logic                ev;
    logic signed [W-1:0] ed;
    logic                es;
    logic                ec;
    logic                eo;
    logic                eb;
    logic [2:0]          en;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [8:0] addr,
                              input logic signed [W-1:0] data, input logic cr,
                              input logic cd, input logic ev,
                              input logic signed [W-1:0] ed, input logic es,
                              input logic ec, input logic eo, input logic eb,
                              input logic [2:0] en);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.cr = cr; v.cd = cd;
    v.ev = ev; v.ed = ed; v.es = es; v.ec = ec; v.eo = eo; v.eb = eb; v.en = en;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev,
                               input logic signed [W-1:0] ed, input logic es,
                               input logic ec, input logic eo, input logic eb,
                               input logic [2:0] en);
    check({tag, ".valid"},   32'(OutValid),   32'(ev));
    check({tag, ".dato"},    32'(OutDato),    32'(ed));
    check({tag, ".start"},   32'(StartOut),   32'(es));
    check({tag, ".clear"},   32'(ClearError), 32'(ec));
    check({tag, ".overrun"}, 32'(Overrun),    32'(eo));
    check({tag, ".busy"},    32'(Busy),       32'(eb));
    check({tag, ".count"},   32'(Count),      32'(en));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic drive(input logic wr, input logic [8:0] addr,
                       input logic signed [W-1:0] data, input logic cr,
                       input logic cd);
    @(negedge clk);
    Write = wr; Address = addr; InDato = data; CoreReady = cr; CoreDone = cd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Write = 1'b0; Address = 9'h000; InDato = '0; CoreReady = 1'b0; CoreDone = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    //            wr addr     data           cr cd  ev ed             es ec eo eb count
    // Fill the first batch, with an early start that must be ignored.
    vecs.push_back(mk(1, 9'h002,  24'sd10,      0, 0,  0, 0,             0, 0, 0, 0, 3'd1));
    vecs.push_back(mk(1, 9'h002, -24'sd5,       0, 0,  0, 0,             0, 0, 0, 0, 3'd2));
    vecs.push_back(mk(1, 9'h003,  24'sd1,       0, 0,  0, 0,             0, 0, 0, 0, 3'd2));
    vecs.push_back(mk(1, 9'h002,  24'sd7,       0, 0,  0, 0,             0, 0, 0, 0, 3'd3));
    vecs.push_back(mk(1, 9'h002,  24'h7FFFFF,   0, 0,  0, 0,             0, 0, 0, 0, 3'd4));
    // Fifth data write overruns; error clear drops it again for one pulse.
    vecs.push_back(mk(1, 9'h002,  24'sd99,      0, 0,  0, 0,             0, 0, 1, 0, 3'd4));
    vecs.push_back(mk(1, 9'h005,  24'sd1,       0, 0,  0, 0,             0, 1, 0, 0, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       0, 0,  0, 0,             0, 0, 0, 0, 3'd4));
    // Unmapped / read-only addresses and a start with a wrong code.
    vecs.push_back(mk(1, 9'h000,  24'sd1,       0, 0,  0, 0,             0, 0, 0, 0, 3'd4));
    vecs.push_back(mk(1, 9'h001,  24'sd1,       0, 0,  0, 0,             0, 0, 0, 0, 3'd4));
    vecs.push_back(mk(1, 9'h004,  24'sd1,       0, 0,  0, 0,             0, 0, 0, 0, 3'd4));
    vecs.push_back(mk(1, 9'h003,  24'sd2,       0, 0,  0, 0,             0, 0, 0, 0, 3'd4));
    // Start and stream with CoreReady held high.
    vecs.push_back(mk(1, 9'h003,  24'sd1,       1, 0,  1, 24'sd10,       1, 0, 0, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       1, 0,  1, -24'sd5,       0, 0, 0, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       1, 0,  1, 24'sd7,        0, 0, 0, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       1, 0,  1, 24'h7FFFFF,    0, 0, 0, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       1, 0,  0, 0,             0, 0, 0, 1, 3'd4));
    vecs.push_back(mk(1, 9'h002,  24'sd55,      1, 0,  0, 0,             0, 0, 1, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       0, 1,  0, 0,             0, 0, 1, 0, 3'd0));
    vecs.push_back(mk(1, 9'h005,  24'sd1,       0, 0,  0, 0,             0, 1, 0, 0, 3'd0));
    // Second batch: stall on the 2nd sample, CoreDone in STREAM, data write mid-stream.
    vecs.push_back(mk(1, 9'h002,  24'sd100,     0, 0,  0, 0,             0, 0, 0, 0, 3'd1));
    vecs.push_back(mk(1, 9'h002, -24'sd200,     0, 0,  0, 0,             0, 0, 0, 0, 3'd2));
    vecs.push_back(mk(1, 9'h002,  24'sd300,     0, 0,  0, 0,             0, 0, 0, 0, 3'd3));
    vecs.push_back(mk(1, 9'h002, -24'sd400,     0, 0,  0, 0,             0, 0, 0, 0, 3'd4));
    vecs.push_back(mk(1, 9'h003,  24'sd1,       0, 0,  1, 24'sd100,      1, 0, 0, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       1, 0,  1, -24'sd200,     0, 0, 0, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       0, 1,  1, -24'sd200,     0, 0, 0, 1, 3'd4));
    vecs.push_back(mk(1, 9'h002,  24'sd777,     0, 0,  1, -24'sd200,     0, 0, 1, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       0, 0,  1, -24'sd200,     0, 0, 1, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       1, 0,  1, 24'sd300,      0, 0, 1, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       1, 0,  1, -24'sd400,     0, 0, 1, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       1, 0,  0, 0,             0, 0, 1, 1, 3'd4));
    vecs.push_back(mk(0, 9'h000,  24'sd0,       0, 1,  0, 0,             0, 0, 1, 0, 3'd0));
    vecs.push_back(mk(1, 9'h005,  24'sd1,       0, 0,  0, 0,             0, 1, 0, 0, 3'd0));
    // Third batch: flush right after start, with CoreReady and CoreDone high.
    vecs.push_back(mk(1, 9'h002,  24'sd5,       0, 0,  0, 0,             0, 0, 0, 0, 3'd1));
    vecs.push_back(mk(1, 9'h002,  24'sd6,       0, 0,  0, 0,             0, 0, 0, 0, 3'd2));
    vecs.push_back(mk(1, 9'h002,  24'sd7,       0, 0,  0, 0,             0, 0, 0, 0, 3'd3));
    vecs.push_back(mk(1, 9'h002,  24'sd8,       0, 0,  0, 0,             0, 0, 0, 0, 3'd4));
    vecs.push_back(mk(1, 9'h003,  24'sd1,       0, 0,  1, 24'sd5,        1, 0, 0, 1, 3'd4));
    vecs.push_back(mk(1, 9'h006,  24'sd1,       1, 1,  0, 0,             0, 0, 0, 0, 3'd0));
    vecs.push_back(mk(1, 9'h002,  24'sd9,       0, 0,  0, 0,             0, 0, 0, 0, 3'd1));
    vecs.push_back(mk(1, 9'h006,  24'sd1,       0, 0,  0, 0,             0, 0, 0, 0, 3'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].cr, vecs[i].cd);
      check_outputs($sformatf("v%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].es,
                    vecs[i].ec, vecs[i].eo, vecs[i].eb, vecs[i].en);
    end

    // Reach WAIT_DONE with Overrun set, then reset asynchronously between edges.
    for (int i = 0; i < D; i++) drive(1, 9'h002, W'(11 + i), 0, 0);
    drive(1, 9'h003, 24'sd1, 1, 0);
    check_outputs("wd_start", 1, 24'sd11, 1, 0, 0, 1, 3'd4);
    for (int i = 0; i < D; i++) drive(0, 9'h000, 24'sd0, 1, 0);
    drive(1, 9'h002, 24'sd42, 0, 0);
    check_outputs("wd_hold", 0, 0, 0, 0, 1, 1, 3'd4);
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-stream as well, then confirm a fresh batch is accepted.
    for (int i = 0; i < D; i++) drive(1, 9'h002, -W'(i + 1), 0, 0);
    drive(1, 9'h003, 24'sd1, 0, 0);
    check_outputs("ms_start", 1, -24'sd1, 1, 0, 0, 1, 3'd4);
    @(negedge clk);
    idle_inputs();
    #3 reset = 1'b1;
    #1;
    check_outputs("ms_reset", 0, 0, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 9'h002, -24'sd8388608, 0, 0);
    check_outputs("post_reset", 0, 0, 0, 0, 0, 0, 3'd1);

    @(negedge clk);
    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
